// File: rtl/rate_meter.sv
// rate_meter: counts synced rising edges of sig_in per GATE_CYCLES window; optional sticky fault via RATE_METER_STICKY_EN.
// Latency: sig_in edge reaches the edge counter after SYNC_STAGES+1 cycles; count/valid update 1 cycle after the terminal cycle.
// Backpressure: none; valid is a one-cycle strobe and results hold until the next one.
module rate_meter #(
  parameter int     GATE_CYCLES = 12000,
  parameter int     CNT_W       = 16,
  parameter longint MIN_COUNT   = 0,
  parameter longint MAX_COUNT   = 65535,
  parameter int     SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             sig_in,
`ifdef RATE_METER_STICKY_EN
  input  logic             fault_clr,
  output logic             fault,
`endif
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             sat,
  output logic             in_range
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [63:0]      MIN_U     = 64'(MIN_COUNT);
  localparam logic [63:0]      MAX_U     = 64'(MAX_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic [GW-1:0]          gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf;

  logic             synced;
  logic             edge_det;
  logic             at_max;
  logic             terminal;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_next;
  logic [63:0]      cnt_ext;
  logic             ge_min;
  logic             le_max;
  logic             range_next;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign edge_det = synced & ~sync_prev;
  assign at_max   = (edge_cnt == CNT_MAX);
  assign terminal = (gate_cnt == GATE_LAST);
  assign cnt_next = (edge_det && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
  // An edge landing on a saturated counter is the only way to lose information.
  assign sat_next = ovf | (edge_det & at_max);
  assign cnt_ext  = 64'(cnt_next);

  // A zero lower bound is trivially met; skipping the compare avoids a constant unsigned test.
  if (MIN_COUNT == 0) begin : g_min_zero
    assign ge_min = 1'b1;
  end else begin : g_min_cmp
    assign ge_min = (cnt_ext >= MIN_U);
  end
  assign le_max     = (cnt_ext <= MAX_U);
  assign range_next = ge_min & le_max;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      ovf       <= 1'b0;
      count     <= '0;
      valid     <= 1'b0;
      sat       <= 1'b0;
      in_range  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_prev <= synced;
      valid     <= terminal;
      if (terminal) begin
        // Terminal-cycle edge is folded into the closing window; the new window starts empty.
        gate_cnt <= '0;
        count    <= cnt_next;
        sat      <= sat_next;
        in_range <= range_next;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= cnt_next;
        ovf      <= sat_next;
      end
    end
  end

`ifdef RATE_METER_STICKY_EN
  logic fault_set;
  assign fault_set = terminal & (~range_next | sat_next);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      fault <= 1'b0;
    end else if (fault_set) begin
      fault <= 1'b1;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rate_meter.sv
// Randomized bench for rate_meter: three parameterizations share one stimulus, checked against a window-sum edge model.
module tb_rate_meter;
  localparam int G    = 100;
  localparam int MAXP = 8000;

  logic        clk;
  logic        resetb;
  logic        sig_in;
  logic        fault_clr;
  logic [15:0] count_m;
  logic [2:0]  count_s;
  logic [7:0]  count_i;
  logic        valid_m, valid_s, valid_i;
  logic        sat_m, sat_s, sat_i;
  logic        rng_m, rng_s, rng_i;
`ifdef RATE_METER_STICKY_EN
  logic        fault_m, fault_s, fault_i;
`endif

  rate_meter #(.GATE_CYCLES(G), .CNT_W(16), .MIN_COUNT(9), .MAX_COUNT(11), .SYNC_STAGES(2)) u_main (
    .clk(clk), .resetb(resetb), .sig_in(sig_in),
`ifdef RATE_METER_STICKY_EN
    .fault_clr(fault_clr), .fault(fault_m),
`endif
    .count(count_m), .valid(valid_m), .sat(sat_m), .in_range(rng_m));

  rate_meter #(.GATE_CYCLES(G), .CNT_W(3), .MIN_COUNT(0), .MAX_COUNT(5), .SYNC_STAGES(2)) u_sat (
    .clk(clk), .resetb(resetb), .sig_in(sig_in),
`ifdef RATE_METER_STICKY_EN
    .fault_clr(fault_clr), .fault(fault_s),
`endif
    .count(count_s), .valid(valid_s), .sat(sat_s), .in_range(rng_s));

  rate_meter #(.GATE_CYCLES(G), .CNT_W(8), .MIN_COUNT(5), .MAX_COUNT(2), .SYNC_STAGES(3)) u_inv (
    .clk(clk), .resetb(resetb), .sig_in(sig_in),
`ifdef RATE_METER_STICKY_EN
    .fault_clr(fault_clr), .fault(fault_i),
`endif
    .count(count_i), .valid(valid_i), .sat(sat_i), .in_range(rng_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: sig_in as sampled at each rising edge since reset release (index 0 = reset edge).
  bit samp [0:MAXP];
  int p;
  bit lvl;
  int hold_left;
  int half_lo, half_hi;
  int last_m;
  int sum_cnt;
  bit exp_fault;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (p=%0d)", tag, got, exp, p);
    end
  endtask

  function automatic int edges_in(input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++)
      if (n >= 1 && n <= MAXP && samp[n] && !samp[n-1]) c++;
    return c;
  endfunction

  function automatic int sat_to(input int raw, input int mx);
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic verify(input bit clr);
    int k, raw2, raw3, cm, cs, ci;
    bit bad;
    if (p % G == 0) begin
      k    = p / G;
      raw2 = edges_in((k-1)*G + 1 - 2, k*G - 2);
      raw3 = edges_in((k-1)*G + 1 - 3, k*G - 3);
      cm = sat_to(raw2, 65535);
      cs = sat_to(raw2, 7);
      ci = sat_to(raw3, 255);
      check("valid_close", {valid_m, valid_s, valid_i}, 3'b111);
      check("main_count", count_m, cm);
      check("main_sat", sat_m, 0);
      check("main_range", rng_m, (cm >= 9 && cm <= 11));
      check("sat_count", count_s, cs);
      check("sat_flag", sat_s, (raw2 > 7));
      check("sat_range", rng_s, (cs <= 5));
      check("inv_count", count_i, ci);
      check("inv_range", rng_i, 0);
      last_m  = cm;
      sum_cnt += cm;
      bad = !(cm >= 9 && cm <= 11);
      if (bad) exp_fault = 1'b1;
      else if (clr) exp_fault = 1'b0;
`ifdef RATE_METER_STICKY_EN
      check("fault_close", fault_m, exp_fault);
`endif
    end else begin
      check("valid_idle", {valid_m, valid_s, valid_i}, 3'b000);
      if (clr) exp_fault = 1'b0;
      if (p % G == G/2) check("main_hold", count_m, last_m);
`ifdef RATE_METER_STICKY_EN
      if (clr || p % G == 1) check("fault_track", fault_m, exp_fault);
`endif
    end
  endtask

  task automatic step(input bit clr);
    @(negedge clk);
    resetb    = 1'b1;
    fault_clr = clr;
    if (half_lo == 0) begin
      lvl = 1'b0;
      hold_left = 0;
    end else begin
      if (hold_left == 0) begin
        lvl = !lvl;
        hold_left = $urandom_range(half_hi, half_lo);
      end
      hold_left--;
    end
    sig_in = lvl;
    @(posedge clk);
    p++;
    if (p <= MAXP) samp[p] = sig_in;
    #1;
    verify(clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetb    = 1'b0;
    fault_clr = 1'b0;
    @(posedge clk);
    #1;
    check("rst_count", {count_m, 5'(count_s), 8'(count_i)}, 0);
    check("rst_valid", {valid_m, valid_s, valid_i}, 0);
    check("rst_sat", {sat_m, sat_s, sat_i}, 0);
    check("rst_range", {rng_m, rng_s, rng_i}, 0);
`ifdef RATE_METER_STICKY_EN
    check("rst_fault", {fault_m, fault_s, fault_i}, 0);
`endif
    p = 0;
    for (int i = 0; i <= MAXP; i++) samp[i] = 1'b0;
    last_m    = 0;
    exp_fault = 1'b0;
  endtask

  task automatic run(input int lo, input int hi, input int nwin);
    half_lo = lo;
    half_hi = hi;
    for (int i = 0; i < nwin * G; i++) step(1'b0);
  endtask

  initial begin
    resetb = 1'b0; sig_in = 1'b0; fault_clr = 1'b0;
    lvl = 1'b0; hold_left = 0; half_lo = 0; half_hi = 0;
    p = 0; last_m = 0; sum_cnt = 0; exp_fault = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();

    run(5, 5, 3);                 // nominal period 10
    sum_cnt = 0;
    run(5, 5, 10);
    check("nominal_sum10", sum_cnt, 100);

    run(10, 10, 3);               // period 20: count 5, out of band
    check("slow_count", count_m, 5);
    run(5, 5, 2);                 // back in band, sticky fault persists
    half_lo = 5; half_hi = 5;
    step(1'b1);
    run(5, 5, 1);

    run(2, 2, 3);                 // period 4: saturates the 3-bit counter
    check("fast_sat_count", count_s, 7);
    check("fast_sat_flag", sat_s, 1);
    run(25, 25, 2);               // period 50
    check("slow_sat_count", count_s, 2);
    check("slow_sat_flag", sat_s, 0);

    run(2, 12, 6);                // random legal rates
    run(0, 0, 2);                 // idle
    check("idle_count", count_m, 0);
    check("idle_range_min0", rng_s, 1);

    half_lo = 3; half_hi = 9;
    while (p % G != 50) step(1'b0);
    do_reset();                   // mid-window abort
    run(3, 9, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
